// File: rtl/bram_avg_engine_if.sv
// Control and memory-port bundle for bram_avg_engine.
// The slave side is the engine. The master side is the job controller plus the BRAM model.
interface bram_avg_engine_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 8
);
  logic              start;
  logic [ADDR_W-1:0] src_base;
  logic [ADDR_W-1:0] dst_base;
  logic [ADDR_W:0]   len;
  logic              busy;
  logic              done;
  logic [ADDR_W-1:0] mem_addr_a;
  logic [DATA_W-1:0] mem_rdata_a;
  logic [ADDR_W-1:0] mem_addr_b;
  logic              mem_we_b;
  logic [DATA_W-1:0] mem_wdata_b;

  modport master (
    output start, src_base, dst_base, len, mem_rdata_a,
    input  busy, done, mem_addr_a, mem_addr_b, mem_we_b, mem_wdata_b
  );
  modport slave (
    input  start, src_base, dst_base, len, mem_rdata_a,
    output busy, done, mem_addr_a, mem_addr_b, mem_we_b, mem_wdata_b
  );
endinterface

// File: rtl/bram_avg_engine.sv
// Streams len signed samples from src to dst as y[i] = floor((x[i] + x[i-1]) / 2).
// The sample before the first one is taken as 0. Each sample uses three cycles: RD, LAT and WR.
module bram_avg_engine #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 8
) (
  input logic clk,
  input logic rst,
  bram_avg_engine_if.slave bus
);
  typedef enum logic [2:0] {IDLE, RD, LAT, WR, DONE} state_t;

  localparam logic [ADDR_W:0] MAX_LEN = {1'b1, {ADDR_W{1'b0}}};

  state_t            state;
  logic [ADDR_W-1:0] src, dst;
  logic [ADDR_W:0]   cnt, i, i_nx, len_c;
  logic [DATA_W-1:0] x, prev;
  logic signed [DATA_W:0]   xs, ps, sum;
  logic signed [DATA_W-1:0] avg;

  assign len_c = (bus.len > MAX_LEN) ? MAX_LEN : bus.len;
  assign i_nx  = i + 1'b1;
  // Sign-extend by one bit so the sum cannot overflow before the halving shift.
  assign xs  = {bus.mem_rdata_a[DATA_W-1], bus.mem_rdata_a};
  assign ps  = {prev[DATA_W-1], prev};
  assign sum = xs + ps;
  assign avg = DATA_W'(sum >>> 1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      src             <= '0;
      dst             <= '0;
      cnt             <= '0;
      i               <= '0;
      x               <= '0;
      prev            <= '0;
      bus.busy        <= 1'b0;
      bus.done        <= 1'b0;
      bus.mem_addr_a  <= '0;
      bus.mem_addr_b  <= '0;
      bus.mem_we_b    <= 1'b0;
      bus.mem_wdata_b <= '0;
    end else begin
      bus.done     <= 1'b0;
      bus.mem_we_b <= 1'b0;
      case (state)
        IDLE: if (bus.start) begin
          bus.busy <= 1'b1;
          if (bus.len == '0) begin
            state    <= DONE;
            bus.done <= 1'b1;
          end else begin
            src            <= bus.src_base;
            dst            <= bus.dst_base;
            cnt            <= len_c;
            i              <= '0;
            prev           <= '0;
            bus.mem_addr_a <= bus.src_base;
            state          <= RD;
          end
        end
        RD: state <= LAT;
        LAT: begin
          x               <= bus.mem_rdata_a;
          bus.mem_wdata_b <= avg;
          bus.mem_addr_b  <= dst + i[ADDR_W-1:0];
          bus.mem_we_b    <= 1'b1;
          state           <= WR;
        end
        WR: begin
          prev <= x;
          i    <= i_nx;
          if (i == cnt - 1'b1) begin
            state    <= DONE;
            bus.done <= 1'b1;
          end else begin
            bus.mem_addr_a <= src + i_nx[ADDR_W-1:0];
            state          <= RD;
          end
        end
        DONE: begin
          bus.busy <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_bram_avg_engine.sv
// Directed and random jobs checked against an array-based model of the averaging rule.
// The model also covers the 1024-word wrap and the length clamp.
module tb_bram_avg_engine;
  logic clk = 1'b0;
  logic rst;
  logic clr, ld;
  logic [9:0] ld_a;
  logic [7:0] ld_d;
  logic [7:0] mem [1024];
  logic [7:0] ref_mem [1024];
  int tests = 0, fails = 0;

  always #5 clk = ~clk;

  bram_avg_engine_if #(.ADDR_W(10), .DATA_W(8)) bus ();
  bram_avg_engine #(.ADDR_W(10), .DATA_W(8)) dut (.clk(clk), .rst(rst), .bus(bus));

  // BRAM model with a registered read port and a write port.
  always @(posedge clk) begin
    if (clr) begin
      for (int k = 0; k < 1024; k++) mem[k] <= 8'h00;
    end else if (ld) mem[ld_a] <= ld_d;
    else if (bus.mem_we_b) mem[bus.mem_addr_b] <= bus.mem_wdata_b;
    bus.mem_rdata_a <= mem[bus.mem_addr_a];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic load(input int a, input logic [7:0] d);
    ld = 1'b1; ld_a = 10'(a); ld_d = d;
    ref_mem[a % 1024] = d;
    @(negedge clk);
    ld = 1'b0;
  endtask

  // Reference model. Samples are processed in order, and only the first nwr results are stored.
  task automatic ref_job(input int src, input int dst, input int len, input int nwr);
    int n, x, prev, s, y;
    n = (len > 1024) ? 1024 : len;
    if (nwr < n) n = nwr;
    prev = 0;
    for (int k = 0; k < n; k++) begin
      x = int'($signed(ref_mem[(src + k) % 1024]));
      s = x + prev;
      y = (s < 0 && (s % 2) != 0) ? s / 2 - 1 : s / 2;
      ref_mem[(dst + k) % 1024] = 8'(y);
      prev = x;
    end
  endtask

  task automatic mem_cmp(input string tag);
    int bad = 0;
    for (int k = 0; k < 1024; k++) if (mem[k] !== ref_mem[k]) bad++;
    check(tag, bad, 0);
  endtask

  task automatic run_job(input string tag, input int src, input int dst, input int len, input bit poke);
    int lat, nwe, lc;
    lc = (len > 1024) ? 1024 : len;
    bus.start = 1'b1; bus.src_base = 10'(src); bus.dst_base = 10'(dst); bus.len = 11'(len);
    @(negedge clk);
    bus.start = 1'b0;
    lat = 1; nwe = 0;
    while (!bus.done && lat < 5000) begin
      if (bus.mem_we_b) nwe++;
      if (poke && lat == 5) begin
        bus.start = 1'b1; bus.src_base = 10'd7; bus.dst_base = 10'd9; bus.len = 11'd3;
      end
      if (poke && lat == 6) bus.start = 1'b0;
      @(negedge clk);
      lat++;
    end
    check({tag, "_lat"}, lat, 3 * lc + 1);
    check({tag, "_nwe"}, nwe, lc);
    @(negedge clk);
    check({tag, "_done_pulse"}, {bus.done, bus.busy}, 2'b00);
    ref_job(src, dst, len, 1 << 20);
    mem_cmp({tag, "_mem"});
  endtask

  initial begin
    int s, d, l, nwe, cyc;
    bit seen_done;
    rst = 1'b1; clr = 1'b1; ld = 1'b0; ld_a = '0; ld_d = '0;
    bus.start = 1'b0; bus.src_base = '0; bus.dst_base = '0; bus.len = '0;
    for (int k = 0; k < 1024; k++) ref_mem[k] = 8'h00;
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_we", bus.mem_we_b, 0);
    check("rst_addr_a", bus.mem_addr_a, 0);
    check("rst_addr_b", bus.mem_addr_b, 0);
    check("rst_wdata", bus.mem_wdata_b, 0);
    rst = 1'b0; clr = 1'b0; bus.start = 1'b0;
    @(negedge clk);

    // Basic example.
    load(0, 8'd10); load(1, 8'd20); load(2, 8'hE2); load(3, 8'd127);
    run_job("basic", 0, 100, 4, 0);
    check("basic_y0", mem[100], 8'd5);
    check("basic_y1", mem[101], 8'd15);
    check("basic_y2", mem[102], 8'hFB);
    check("basic_y3", mem[103], 8'd48);

    // Negative extremes and floor rounding.
    load(0, 8'h80); load(1, 8'h80);
    run_job("neg", 0, 200, 2, 0);
    check("neg_y0", mem[200], 8'hC0);
    check("neg_y1", mem[201], 8'h80);
    load(10, 8'hFF);
    run_job("floor", 10, 300, 1, 0);
    check("floor_y0", mem[300], 8'hFF);

    // In-place job that wraps past address 1023.
    load(1022, 8'd2); load(1023, 8'd4); load(0, 8'd6); load(1, 8'd8);
    run_job("wrap", 1022, 1022, 4, 0);
    check("wrap_1022", mem[1022], 8'd1);
    check("wrap_1023", mem[1023], 8'd3);
    check("wrap_0", mem[0], 8'd5);
    check("wrap_1", mem[1], 8'd7);

    // A zero-length job, then a start pulse during a running job.
    run_job("zero", 5, 5, 0, 0);
    for (int k = 0; k < 6; k++) load(50 + k, 8'($urandom));
    run_job("poke", 50, 60, 6, 1);

    // Random jobs. Overlapping buffers are allowed.
    for (int j = 0; j < 6; j++) begin
      s = int'($urandom_range(0, 1023));
      d = int'($urandom_range(0, 1023));
      l = int'($urandom_range(1, 40));
      for (int k = 0; k < l; k++) load((s + k) % 1024, 8'($urandom));
      run_job($sformatf("rnd%0d", j), s, d, l, 0);
    end

    // A length above 1024 is clamped to a full sweep.
    run_job("clamp", 17, 600, 1500, 0);

    // Reset during the second write of a len=8 job.
    for (int k = 0; k < 8; k++) load(700 + k, 8'($urandom));
    bus.start = 1'b1; bus.src_base = 10'd700; bus.dst_base = 10'd800; bus.len = 11'd8;
    @(negedge clk);
    bus.start = 1'b0;
    nwe = 0; cyc = 0;
    while (nwe < 2 && cyc < 100) begin
      if (bus.mem_we_b) nwe++;
      if (nwe < 2) @(negedge clk);
      cyc++;
    end
    check("abort_reach_wr2", nwe, 2);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_we", bus.mem_we_b, 0);
    check("abort_busy", bus.busy, 0);
    check("abort_done", bus.done, 0);
    seen_done = 1'b0;
    for (int k = 0; k < 30; k++) begin
      if (bus.done || bus.mem_we_b) seen_done = 1'b1;
      @(negedge clk);
    end
    check("abort_quiet", seen_done, 0);
    ref_job(700, 800, 8, 2);
    mem_cmp("abort_mem");
    run_job("after_abort", 700, 900, 8, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
